// File: rtl/regfile_mp_sb_if.sv
// Register file bus: read ports, write ports, issue and scoreboard status.
// The pipeline drives the master side; the register file is the slave.
interface regfile_mp_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [AW-1:0]   ra1;
    logic [AW-1:0]   ra2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            busy1;
    logic            busy2;
    logic            we0;
    logic [AW-1:0]   wa0;
    logic [XLEN-1:0] wd0;
    logic            we1;
    logic [AW-1:0]   wa1;
    logic [XLEN-1:0] wd1;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic [AW:0]     pend_cnt;

    modport master (
        output ra1, ra2,
        output we0, wa0, wd0,
        output we1, wa1, wd1,
        output iss_valid, iss_rd,
        input  rd1, rd2,
        input  busy1, busy2,
        input  pend_cnt
    );

    modport slave (
        input  ra1, ra2,
        input  we0, wa0, wd0,
        input  we1, wa1, wd1,
        input  iss_valid, iss_rd,
        output rd1, rd2,
        output busy1, busy2,
        output pend_cnt
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// 2R/2W register file with pending-write scoreboard.
// Port 1 (load writeback) wins over port 0 on an address clash.
module regfile_mp_sb #(
    parameter int XLEN     = 32,
    parameter int N_REG    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic           clk,
    input logic           reset,
    regfile_mp_sb_if.slave bus
);
    localparam logic [AW:0] NR = (AW+1)'(N_REG);

    // An address is usable if in range and not the hardwired zero reg.
    function automatic logic ok(input logic [AW-1:0] a);
        logic z;
        z = (ZERO_REG != 0) && (a == '0);
        return ({1'b0, a} < NR) && !z;
    endfunction

    logic [XLEN-1:0] regs [N_REG];
    logic [N_REG-1:0] pend;
    logic [N_REG-1:0] pend_n;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_n;

    logic             wv0;
    logic             wv1;
    logic             iv;
    logic [AW-1:0]    ra [2];
    logic [XLEN-1:0]  rd [2];
    logic             bz [2];

    assign wv0 = bus.we0 & ok(bus.wa0);
    assign wv1 = bus.we1 & ok(bus.wa1);
    assign iv  = bus.iss_valid & ok(bus.iss_rd);

    assign ra[0] = bus.ra1;
    assign ra[1] = bus.ra2;

    assign bus.rd1      = rd[0];
    assign bus.rd2      = rd[1];
    assign bus.busy1    = bz[0];
    assign bus.busy2    = bz[1];
    assign bus.pend_cnt = cnt_q;

    // Read ports: stored value or same-cycle forward, busy masking.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd[p] = '0;
            bz[p] = 1'b0;
            if (!reset && ok(ra[p])) begin
                rd[p] = regs[ra[p]];
                bz[p] = pend[ra[p]];
                if (BYPASS != 0) begin
                    if (wv0 && bus.wa0 == ra[p])
                        rd[p] = bus.wd0;
                    if (wv1 && bus.wa1 == ra[p])
                        rd[p] = bus.wd1;
                    if (((wv0 && bus.wa0 == ra[p]) ||
                         (wv1 && bus.wa1 == ra[p])) &&
                        !(iv && bus.iss_rd == ra[p]))
                        bz[p] = 1'b0;
                end
            end
        end
    end

    // Scoreboard next state: issue sets, writeback clears, issue wins.
    always_comb begin
        pend_n = pend;
        cnt_n  = '0;
        for (int r = 0; r < N_REG; r++) begin
            if (iv && bus.iss_rd == AW'(r))
                pend_n[r] = 1'b1;
            else if ((wv0 && bus.wa0 == AW'(r)) ||
                     (wv1 && bus.wa1 == AW'(r)))
                pend_n[r] = 1'b0;
            cnt_n = cnt_n + (AW+1)'(pend_n[r]);
        end
    end

    // Register array write; port 1 overrides port 0 on the same address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < N_REG; r++)
                regs[r] <= '0;
        end else begin
            for (int r = 0; r < N_REG; r++) begin
                if (wv1 && bus.wa1 == AW'(r))
                    regs[r] <= bus.wd1;
                else if (wv0 && bus.wa0 == AW'(r))
                    regs[r] <= bus.wd0;
            end
        end
    end

    // Pending bits and their registered population count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend  <= '0;
            cnt_q <= '0;
        end else begin
            pend  <= pend_n;
            cnt_q <= cnt_n;
        end
    end
endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised successor register file for the pipelined core: 2 combinational read ports, 2 synchronous write ports (ALU writeback, load writeback), optional hardwired-zero r0, optional same-cycle write-to-read bypass.
- Integrated pending-write scoreboard: issue marks destination busy, writeback clears it; busy flags per read port feed the hazard/stall logic.
- Sits between decode (read/issue) and writeback stages.

Parameters:
- XLEN, 32, data width in bits.
- N_REG, 32, number of architectural registers (2..64, need not be power of 2).
- AW, 5, address width; must satisfy 2**AW >= N_REG.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never marked busy.
- BYPASS, 1, 1 = read ports forward same-cycle write data and suppress busy for that register.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all registers and scoreboard.
- ra1  in  AW  read port 1 address.
- ra2  in  AW  read port 2 address.
- rd1  out  XLEN  read port 1 data.
- rd2  out  XLEN  read port 2 data.
- busy1  out  1  register at ra1 has a write outstanding.
- busy2  out  1  register at ra2 has a write outstanding.
- we0  in  1  write enable, port 0 (ALU writeback).
- wa0  in  AW  write address, port 0.
- wd0  in  XLEN  write data, port 0.
- we1  in  1  write enable, port 1 (load writeback); higher priority.
- wa1  in  AW  write address, port 1.
- wd1  in  XLEN  write data, port 1.
- iss_valid  in  1  instruction issued with a destination register.
- iss_rd  in  AW  destination register of issued instruction.
- pend_cnt  out  AW+1  number of registers currently marked pending (registered).

Behaviour:
- Reset (async): all registers = 0, pending bits = 0, pend_cnt = 0. rd1/rd2 = 0 and busy1/busy2 = 0 while reset is asserted (combinational from cleared state).
- Write: on posedge clk, if weN and waN < N_REG, register[waN] <= wdN. Both ports to the same address: port 1 wins. Different addresses: both write.
- ZERO_REG=1: writes to address 0 dropped; rd for address 0 = 0; pending[0] never set.
- Out-of-range address (>= N_REG): write dropped, issue dropped, read returns 0, busy 0.
- Read: combinational, 0-cycle latency. With BYPASS=1, if a write to raN is valid this cycle, rdN = that write data (port 1 over port 0); otherwise stored value. With BYPASS=0, rdN = stored value; the new value is visible the cycle after the write.
- Scoreboard, per register, at posedge: set if iss_valid & iss_rd == r; else clear if (we0 & wa0 == r) or (we1 & wa1 == r); else hold. Issue and writeback to the same register in the same cycle: pending stays set (a new producer is outstanding).
- Writeback to a non-pending register writes data and leaves pending 0; this is not an error.
- busyN = pending[raN], except with BYPASS=1 it is 0 when a write to raN occurs this cycle and no same-cycle issue targets raN.
- pend_cnt = popcount of pending bits after the clock edge; updated each cycle; max N_REG-ZERO_REG.
- Reset mid-operation overrides all writes and issues in that cycle; the first writes are accepted on the first edge after reset deasserts.

Test Plan:
- Reset, then read all addresses -> rd1=rd2=0, busy1=busy2=0, pend_cnt=0.
- we0=1, wa0=5, wd0=0xDEADBEEF; ra1=5 same cycle -> BYPASS=1: rd1=0xDEADBEEF immediately; BYPASS=0: rd1=0 that cycle, 0xDEADBEEF the next.
- Same cycle we0 (wa0=7, wd0=0x11) and we1 (wa1=7, wd1=0x22) -> next cycle rd(7)=0x22; with BYPASS=1, same-cycle rd(7)=0x22.
- Write 0xFFFFFFFF to r0 with ZERO_REG=1 -> rd(0)=0; iss_valid with iss_rd=0 -> busy stays 0, pend_cnt unchanged.
- Issue r3 -> busy(r3)=1, pend_cnt=1. Next cycle issue r3 and we1 to r3 with 0x42 -> busy stays 1, data=0x42. Following cycle we0 to r3 -> busy(r3)=0, pend_cnt=0.
- Issue r1, r2, r4; assert reset asynchronously mid-clock -> all pending cleared and pend_cnt=0 immediately; registers read 0.
